async_fifo_rd_sched: RTL and testbench
======================================

// Module: async_fifo_rd_sched
// PURPOSE
//  Read-side scheduler for N async-FIFO read ports in the RD_CLK domain.
//  Arbitrates round-robin among non-empty queues at frame granularity and drives each FIFO's RD_EN.
//  Collects read data (1-cycle read latency) into a credit-managed output buffer feeding one valid/ready stream.
//  Sits between per-queue CDC FIFOs and the egress datapath.
// PARAMETERS
//  N_Q        4   number of FIFO read ports (2..16)
//  DATA_W     65  FIFO word width; bit DATA_W-1 = EOP, bits DATA_W-2:0 = payload
//  OBUF_DEPTH 2   output buffer entries (>=2; 2 sustains one word/cycle)
// PORTS
//  RD_CLK      in   1           read-domain clock
//  RD_RST      in   1           reset
//  FIFO_EMPTY  in   N_Q         per-queue RD_EMPTY from FIFOs
//  FIFO_RD_EN  out  N_Q         per-queue read enable, one-hot or zero
//  FIFO_DATA   in   N_Q*DATA_W  per-queue read data, valid the cycle after RD_EN
//  OUT_DATA    out  DATA_W      head word of output buffer (EOP at MSB)
//  OUT_QID     out  QID_W       source queue of OUT_DATA; QID_W=$clog2(N_Q)
//  OUT_VALID   out  1           output word valid
//  OUT_READY   in   1           downstream accept
//  BUSY        out  1           1 while state=XFER or buffer non-empty
//  GATE_MASK   in   N_Q         per-queue transmit gate (present only with SCHED_GATE_EN)
// BEHAVIOUR
//  Reset: RD_RST asynchronous, active-high; clock RD_CLK. Reset state: IDLE, grant=0, rr_ptr=N_Q-1.
//   Credits = OBUF_DEPTH, buffer empty, in-flight flag 0.
//   Outputs: FIFO_RD_EN=0, OUT_VALID=0, OUT_DATA=0, OUT_QID=0, BUSY=0.
//   Assertion mid-frame discards buffered and in-flight words; the next frame starts clean.
//  eligible[i] = !FIFO_EMPTY[i] (AND GATE_MASK[i] when gated).
//  IDLE: if any eligible, winner = first eligible after rr_ptr (wrapping N_Q-1 -> 0).
//   Register grant=winner and rr_ptr=winner; go to XFER next cycle. Otherwise stay in IDLE.
//  XFER: FIFO_RD_EN[grant] = !FIFO_EMPTY[grant] && (credits>0 || pop) && !ret_eop.
//   pop = OUT_VALID && OUT_READY.
//   ret_eop = inflight && FIFO_DATA[grant][DATA_W-1]; the EOP check is combinational in the same cycle,
//   so the scheduler never reads past EOP.
//  inflight <= |FIFO_RD_EN. When inflight=1, FIFO_DATA[grant] and grant are written into the buffer that cycle.
//  On ret_eop: go to IDLE. Each frame costs one IDLE bubble cycle.
//  FIFO empty mid-frame: hold grant and stall RD_EN. No timeout.
//  Credits: -1 per RD_EN, +1 per pop. Both in one cycle: unchanged. Credits never exceed OBUF_DEPTH
//   and never go below 0; the buffer cannot overflow.
//  Latency: eligible seen in IDLE at T -> RD_EN at T+1 -> buffer write at T+2 -> OUT_VALID at T+3.
//   Back-to-back words 1/cycle while OUT_READY=1 and the FIFO is non-empty.
//  OUT_* are registered buffer head values. OUT_DATA/OUT_QID hold stable while OUT_VALID && !OUT_READY.
//  Frame lock: a granted queue is never preempted; words of two frames never interleave.
// CONFIGURATION
//  `SCHED_GATE_EN defined: GATE_MASK port exists. A gated queue is not eligible for a new grant.
//   Closing the gate mid-frame does not interrupt the current frame.
//  Not defined: no GATE_MASK port; eligibility = !FIFO_EMPTY only.
// STRUCTURE
//  async_fifo_sched_pkg contains: state enum {IDLE, XFER}, QID_W function, EOP bit-index localparam.
//  Sub-module sched_obuf holds the output buffer: OBUF_DEPTH x (DATA_W+QID_W) registered FIFO
//   with push/pop, head outputs and count.
//  Round-robin picker and credit counter stay in the top module.
// TESTING
//  1 Reset: RD_RST=1 with all FIFOs non-empty -> FIFO_RD_EN=0, OUT_VALID=0, BUSY=0; first RD_EN 2 cycles after release.
//  2 Round-robin: queues 0,2,3 each hold one 3-word frame -> output frames in order q0,q2,q3.
//    OUT_QID constant within each frame; no interleave.
//  3 Back-pressure: OUT_READY=0 for 10 cycles mid-frame -> RD_EN stops after 2 reads; data held; no word lost or duplicated.
//  4 EOP then empty: 1-word frame on q1 followed by a second frame -> exactly 1 read, then IDLE.
//    Second frame gets a new grant; no read past EOP.
//  5 Empty mid-frame: q0 empties after word 2 of 5 for 6 cycles -> grant held; remaining 3 words resume on q0.
//  6 Gate (SCHED_GATE_EN): GATE_MASK=4'b1101 with all queues full -> q1 never granted.
//    Clearing gate bit 0 mid-frame on q0 -> that frame completes.

Source files
------------

// File: rtl/async_fifo_sched_pkg.sv
// Shared types and helpers for the async-FIFO read scheduler.
package async_fifo_sched_pkg;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} sched_state_e;

  // EOP sits this many bits below the word width, i.e. at the MSB.
  localparam int EOP_MSB_OFS = 1;

  function automatic int qid_w(input int n_q);
    return (n_q > 1) ? $clog2(n_q) : 1;
  endfunction

endpackage

// File: rtl/sched_obuf.sv
// Output buffer: DEPTH-entry registered FIFO; head outputs come straight from storage.
module sched_obuf #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic                       o_vld,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PW-1:0]           r_wptr, r_rptr;
  logic [CW-1:0]           r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= (r_wptr == PW'(DEPTH-1)) ? '0 : r_wptr + PW'(1);
      end
      if (i_pop)
        r_rptr <= (r_rptr == PW'(DEPTH-1)) ? '0 : r_rptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_vld   = (r_cnt != '0);
  assign o_count = r_cnt;

endmodule

// File: rtl/async_fifo_rd_sched.sv
// Frame-granular round-robin read scheduler over N_Q CDC FIFOs with a credit-managed output buffer.
// Optional SCHED_GATE_EN adds the GATE_MASK port for per-queue grant gating.
module async_fifo_rd_sched
  import async_fifo_sched_pkg::*;
#(
  parameter  int N_Q        = 4,
  parameter  int DATA_W     = 65,
  parameter  int OBUF_DEPTH = 2,
  localparam int QID_W      = qid_w(N_Q)
) (
  input  logic                  RD_CLK,
  input  logic                  RD_RST,
  input  logic [N_Q-1:0]        FIFO_EMPTY,
  output logic [N_Q-1:0]        FIFO_RD_EN,
  input  logic [N_Q*DATA_W-1:0] FIFO_DATA,
  output logic [DATA_W-1:0]     OUT_DATA,
  output logic [QID_W-1:0]      OUT_QID,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  BUSY
`ifdef SCHED_GATE_EN
  ,input logic [N_Q-1:0]        GATE_MASK
`endif
);
  localparam int EOP_BIT = DATA_W - EOP_MSB_OFS;
  localparam int CRW     = $clog2(OBUF_DEPTH+1);

  sched_state_e          r_state, w_state_nxt;
  logic [QID_W-1:0]      r_grant, r_rr_ptr, w_winner, w_idx;
  logic [N_Q-1:0]        w_elig;
  logic                  w_any_elig;
  logic [CRW-1:0]        r_credits;
  logic                  r_inflight;
  logic                  w_pop, w_ret_eop, w_rd_en;
  logic [DATA_W-1:0]     w_gnt_data;
  logic [DATA_W+QID_W-1:0] w_head;
  logic [CRW-1:0]        w_obuf_cnt;

`ifdef SCHED_GATE_EN
  assign w_elig = ~FIFO_EMPTY & GATE_MASK;
`else
  assign w_elig = ~FIFO_EMPTY;
`endif

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < N_Q; i++)
      if (r_grant == QID_W'(i)) w_gnt_data = FIFO_DATA[i*DATA_W +: DATA_W];
  end

  // Search starts just after the last winner so every queue gets its turn.
  always_comb begin
    w_winner   = '0;
    w_any_elig = 1'b0;
    w_idx      = '0;
    for (int k = 1; k <= N_Q; k++) begin
      w_idx = QID_W'((32'(r_rr_ptr) + k) % N_Q);
      if (!w_any_elig && w_elig[w_idx]) begin
        w_any_elig = 1'b1;
        w_winner   = w_idx;
      end
    end
  end

  assign w_pop     = OUT_VALID & OUT_READY;
  // The returning word is inspected the cycle it arrives, so no read ever lands past EOP.
  assign w_ret_eop = r_inflight & w_gnt_data[EOP_BIT];

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    case (r_state)
      IDLE: if (w_any_elig) w_state_nxt = XFER;
      XFER: begin
        w_rd_en = !FIFO_EMPTY[r_grant] && ((r_credits != '0) || w_pop) && !w_ret_eop;
        if (w_ret_eop) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    FIFO_RD_EN          = '0;
    FIFO_RD_EN[r_grant] = w_rd_en;
  end

  always_ff @(posedge RD_CLK or posedge RD_RST) begin
    if (RD_RST) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= QID_W'(N_Q-1);
      r_credits  <= CRW'(OBUF_DEPTH);
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd_en;
      if (r_state == IDLE && w_any_elig) begin
        r_grant  <= w_winner;
        r_rr_ptr <= w_winner;
      end
      case ({w_rd_en, w_pop})
        2'b10:   r_credits <= r_credits - CRW'(1);
        2'b01:   r_credits <= r_credits + CRW'(1);
        default: ;
      endcase
    end
  end

  sched_obuf #(.DEPTH(OBUF_DEPTH), .W(DATA_W+QID_W)) u_obuf (
    .i_clk   (RD_CLK),
    .i_rst   (RD_RST),
    .i_push  (r_inflight),
    .i_data  ({r_grant, w_gnt_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_vld   (OUT_VALID),
    .o_count (w_obuf_cnt)
  );

  assign OUT_QID  = w_head[DATA_W+QID_W-1 -: QID_W];
  assign OUT_DATA = w_head[DATA_W-1:0];
  assign BUSY     = (r_state == XFER) || (w_obuf_cnt != '0);

endmodule

// File: tb/tb_async_fifo_rd_sched.sv
// Scoreboard bench for async_fifo_rd_sched: behavioural FIFOs feed the DUT, outputs are compared in order.
`timescale 1ns/1ps
module tb_async_fifo_rd_sched;
  localparam int N_Q = 4, DATA_W = 65, OBUF_DEPTH = 2, QID_W = 2, MEMD = 256;
  typedef logic [QID_W+DATA_W-1:0] ent_t;

  logic                  RD_CLK = 1'b0;
  logic                  RD_RST = 1'b1;
  logic [N_Q-1:0]        FIFO_EMPTY;
  logic [N_Q-1:0]        FIFO_RD_EN;
  logic [N_Q*DATA_W-1:0] FIFO_DATA = '0;
  logic [DATA_W-1:0]     OUT_DATA;
  logic [QID_W-1:0]      OUT_QID;
  logic                  OUT_VALID;
  logic                  OUT_READY = 1'b1;
  logic                  BUSY;
`ifdef SCHED_GATE_EN
  logic [N_Q-1:0]        GATE_MASK = '1;
`endif

  logic [DATA_W-1:0] fmem [N_Q][MEMD];
  int   wr_ptr [N_Q] = '{default: 0};
  int   rd_ptr [N_Q] = '{default: 0};
  int   bad_rd = 0;
  ent_t obs_mem [1024];
  int   obs_wr = 0, obs_rd = 0;
  ent_t exp_q [$];
  int   checks = 0, errors = 0;

  async_fifo_rd_sched #(.N_Q(N_Q), .DATA_W(DATA_W), .OBUF_DEPTH(OBUF_DEPTH)) dut (
    .RD_CLK     (RD_CLK),
    .RD_RST     (RD_RST),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_RD_EN (FIFO_RD_EN),
    .FIFO_DATA  (FIFO_DATA),
    .OUT_DATA   (OUT_DATA),
    .OUT_QID    (OUT_QID),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .BUSY       (BUSY)
`ifdef SCHED_GATE_EN
    ,.GATE_MASK (GATE_MASK)
`endif
  );

  always #5 RD_CLK = ~RD_CLK;

  always_comb begin
    FIFO_EMPTY = '1;
    for (int i = 0; i < N_Q; i++) FIFO_EMPTY[i] = (wr_ptr[i] == rd_ptr[i]);
  end

  // FIFO read side: data appears the cycle after RD_EN.
  always @(posedge RD_CLK)
    for (int i = 0; i < N_Q; i++)
      if (FIFO_RD_EN[i]) begin
        if (rd_ptr[i] == wr_ptr[i]) bad_rd <= bad_rd + 1;
        else begin
          FIFO_DATA[i*DATA_W +: DATA_W] <= fmem[i][rd_ptr[i] % MEMD];
          rd_ptr[i] <= rd_ptr[i] + 1;
        end
      end

  always @(posedge RD_CLK)
    if (OUT_VALID && OUT_READY) begin
      obs_mem[obs_wr % 1024] <= {OUT_QID, OUT_DATA};
      obs_wr <= obs_wr + 1;
    end

  function automatic logic [DATA_W-1:0] mkw(input int q, input int f, input int i, input bit eop);
    logic [31:0] rnd;
    rnd = $urandom();
    return {eop, rnd, 32'((q << 16) | (f << 8) | i)};
  endfunction

  task automatic put(input int q, input logic [DATA_W-1:0] w);
    fmem[q][wr_ptr[q] % MEMD] = w;
    wr_ptr[q] = wr_ptr[q] + 1;
  endtask

  task automatic load_frame(input int q, input int f, input int n);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = mkw(q, f, i, i == n-1);
      put(q, w);
      exp_q.push_back({QID_W'(q), w});
    end
  endtask

  task automatic wait_out(input int n, output bit ok);
    int t;
    t = 0;
    while ((obs_wr - obs_rd) < n && t < 2000) begin
      @(negedge RD_CLK);
      t++;
    end
    ok = ((obs_wr - obs_rd) >= n);
  endtask

  task automatic test_reset;
    bit ok; ent_t e, g; int n;
    RD_RST = 1'b1;
    for (int q = 0; q < N_Q; q++) load_frame(q, 0, 1);
    repeat (3) @(negedge RD_CLK);
    checks++; if (FIFO_RD_EN !== '0) begin errors++; $display("FAIL rst_rd_en: got %b want 0000", FIFO_RD_EN); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", OUT_VALID); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", BUSY); end
    checks++; if (OUT_DATA !== '0 || OUT_QID !== '0) begin errors++; $display("FAIL rst_out_data: got %h/%0d want 0/0", OUT_DATA, OUT_QID); end
    RD_RST = 1'b0;
    @(negedge RD_CLK);
    checks++; if (FIFO_RD_EN !== 4'b0001) begin errors++; $display("FAIL rst_first_rd_en: got %b want 0001", FIFO_RD_EN); end
    n = exp_q.size();
    wait_out(n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_timeout: got %0d words want %0d", obs_wr-obs_rd, n); exp_q.delete(); obs_rd = obs_wr; end
    else for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front(); g = obs_mem[obs_rd % 1024]; obs_rd++;
      checks++; if (g !== e) begin errors++; $display("FAIL rst_word%0d: got %h want %h", k, g, e); end
    end
  endtask

  task automatic test_round_robin;
    bit ok; ent_t e, g; int n;
    load_frame(0, 1, 3);
    load_frame(2, 1, 3);
    load_frame(3, 1, 3);
    n = exp_q.size();
    wait_out(n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_timeout: got %0d words want %0d", obs_wr-obs_rd, n); exp_q.delete(); obs_rd = obs_wr; end
    else for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front(); g = obs_mem[obs_rd % 1024]; obs_rd++;
      checks++; if (g !== e) begin errors++; $display("FAIL rr_word%0d: got %h want %h", k, g, e); end
    end
    repeat (4) @(negedge RD_CLK);
    checks++; if (obs_wr != obs_rd) begin errors++; $display("FAIL rr_extra_words: got %0d want 0", obs_wr-obs_rd); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rr_idle_busy: got %b want 0", BUSY); end
  endtask

  task automatic test_back_pressure;
    bit ok, held_bad, have; ent_t e, g, snap; int n, base, t;
    base = rd_ptr[1];
    load_frame(1, 2, 6);
    n = exp_q.size();
    t = 0;
    while ((obs_wr - obs_rd) < 2 && t < 200) begin @(negedge RD_CLK); t++; end
    OUT_READY = 1'b0;
    held_bad = 1'b0; have = 1'b0; snap = '0;
    repeat (10) begin
      @(negedge RD_CLK);
      if (OUT_VALID) begin
        if (!have) begin snap = {OUT_QID, OUT_DATA}; have = 1'b1; end
        else if ({OUT_QID, OUT_DATA} !== snap) held_bad = 1'b1;
      end
    end
    checks++; if (held_bad || !have) begin errors++; $display("FAIL bp_hold: got unstable=%0d seen=%0d want 0/1", held_bad, have); end
    checks++; if (FIFO_RD_EN !== '0) begin errors++; $display("FAIL bp_rd_stall: got %b want 0000", FIFO_RD_EN); end
    checks++; if (rd_ptr[1] - base != 2 + OBUF_DEPTH) begin errors++; $display("FAIL bp_reads: got %0d want %0d", rd_ptr[1]-base, 2+OBUF_DEPTH); end
    OUT_READY = 1'b1;
    wait_out(n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: got %0d words want %0d", obs_wr-obs_rd, n); exp_q.delete(); obs_rd = obs_wr; end
    else for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front(); g = obs_mem[obs_rd % 1024]; obs_rd++;
      checks++; if (g !== e) begin errors++; $display("FAIL bp_word%0d: got %h want %h", k, g, e); end
    end
  endtask

  task automatic test_eop_then_empty;
    bit ok; ent_t e, g; int n, base;
    logic [N_Q-1:0] exp_en [6];
    exp_en = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
    base = rd_ptr[1];
    load_frame(1, 3, 1);
    load_frame(1, 4, 2);
    n = exp_q.size();
    for (int c = 0; c < 6; c++) begin
      @(negedge RD_CLK);
      checks++; if (FIFO_RD_EN !== exp_en[c]) begin errors++; $display("FAIL eop_rd_en_c%0d: got %b want %b", c, FIFO_RD_EN, exp_en[c]); end
    end
    wait_out(n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL eop_timeout: got %0d words want %0d", obs_wr-obs_rd, n); exp_q.delete(); obs_rd = obs_wr; end
    else for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front(); g = obs_mem[obs_rd % 1024]; obs_rd++;
      checks++; if (g !== e) begin errors++; $display("FAIL eop_word%0d: got %h want %h", k, g, e); end
    end
    checks++; if (rd_ptr[1] - base != 3 || bad_rd != 0) begin errors++; $display("FAIL eop_reads: got %0d/%0d want 3/0", rd_ptr[1]-base, bad_rd); end
  endtask

  task automatic test_empty_mid_frame;
    bit ok, gap_bad; ent_t e, g; int n, base, t;
    logic [DATA_W-1:0] w [5];
    logic [DATA_W-1:0] w2;
    base = rd_ptr[0];
    for (int i = 0; i < 5; i++) begin
      w[i] = mkw(0, 5, i, i == 4);
      exp_q.push_back({QID_W'(0), w[i]});
    end
    w2 = mkw(2, 6, 0, 1'b1);
    exp_q.push_back({QID_W'(2), w2});
    put(0, w[0]); put(0, w[1]);
    t = 0;
    while (rd_ptr[0] - base < 2 && t < 200) begin @(negedge RD_CLK); t++; end
    put(2, w2);
    gap_bad = 1'b0;
    repeat (6) begin
      @(negedge RD_CLK);
      if (FIFO_RD_EN !== '0 || BUSY !== 1'b1) gap_bad = 1'b1;
    end
    checks++; if (gap_bad) begin errors++; $display("FAIL mid_gap_hold: got rd_en=%b busy=%b want 0000/1", FIFO_RD_EN, BUSY); end
    for (int i = 2; i < 5; i++) put(0, w[i]);
    n = exp_q.size();
    wait_out(n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_timeout: got %0d words want %0d", obs_wr-obs_rd, n); exp_q.delete(); obs_rd = obs_wr; end
    else for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front(); g = obs_mem[obs_rd % 1024]; obs_rd++;
      checks++; if (g !== e) begin errors++; $display("FAIL mid_word%0d: got %h want %h", k, g, e); end
    end
    checks++; if (bad_rd != 0) begin errors++; $display("FAIL mid_read_empty: got %0d want 0", bad_rd); end
  endtask

`ifdef SCHED_GATE_EN
  task automatic test_gate;
    bit ok; ent_t e, g; int n, base0, base1, t;
    GATE_MASK = 4'b1101;
    base0 = rd_ptr[0]; base1 = rd_ptr[1];
    load_frame(3, 10, 2);
    load_frame(0, 7, 4);
    load_frame(2, 9, 2);
    put(1, mkw(1, 8, 0, 1'b0));
    put(1, mkw(1, 8, 1, 1'b1));
    n = exp_q.size();
    t = 0;
    while (rd_ptr[0] - base0 < 1 && t < 200) begin @(negedge RD_CLK); t++; end
    GATE_MASK = 4'b1100;
    wait_out(n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL gate_timeout: got %0d words want %0d", obs_wr-obs_rd, n); exp_q.delete(); obs_rd = obs_wr; end
    else for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front(); g = obs_mem[obs_rd % 1024]; obs_rd++;
      checks++; if (g !== e) begin errors++; $display("FAIL gate_word%0d: got %h want %h", k, g, e); end
    end
    repeat (20) @(negedge RD_CLK);
    checks++; if (rd_ptr[1] != base1) begin errors++; $display("FAIL gate_q1_read: got %0d reads want 0", rd_ptr[1]-base1); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL gate_idle_busy: got %b want 0", BUSY); end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_eop_then_empty();
    test_empty_mid_frame();
`ifdef SCHED_GATE_EN
    test_gate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
